// File: rtl/rotate_read_controller.sv
// Purpose : read a stored W x H RGB frame back from SRAM in 0/90/180/270 deg CW order and stream it out.
// Latency : first out_valid 2 cycles after entering R_READ; 1 pixel/cycle sustained while out_ready=1.
// Backpressure: 2-entry output FIFO; reads are issued only while FIFO entries plus in-flight reads leave room.
//
// Ports:
//   Clk_in, Reset            - single clock, synchronous active-high reset
//   write_finish             - level, frame in SRAM is complete (starts a frame, and R_DONE waits for it to drop)
//   rot_mode[1:0]            - 0=0deg, 1=90 CW, 2=180, 3=270 CW, latched at frame start
//   SRAM_EN_r, SRAM_Addr_r   - SRAM read strobe/address (frame stored row-major, addr = y*W + x)
//   SRAM_Dout                - read data, valid the cycle after SRAM_EN_r
//   pixel_out, out_valid,    - output pixel stream, valid/ready handshake
//   out_ready, out_line_end,
//   out_frame_end
//   read_finish              - high in R_DONE, after the last pixel has been accepted
//
// Build option: define BGR_SWAP_EN to exchange the R and B bytes of pixel_out at the FIFO output.

module rotate_read_controller #(
    parameter int W = 256,
    parameter int H = 256
) (
    input  logic        Clk_in,
    input  logic        Reset,
    input  logic        write_finish,
    input  logic [1:0]  rot_mode,
    output logic        SRAM_EN_r,
    output logic [19:0] SRAM_Addr_r,
    input  logic [23:0] SRAM_Dout,
    output logic [23:0] pixel_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_line_end,
    output logic        out_frame_end,
    output logic        read_finish
);

    localparam logic [19:0] W20 = 20'(W);
    localparam logic [19:0] WM1 = 20'(W - 1);
    localparam logic [19:0] HM1 = 20'(H - 1);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_READ  = 2'd1,
        R_DRAIN = 2'd2,
        R_DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  mode_q;
    logic [19:0] r_q;
    logic [19:0] c_q;

    // Read pipeline: one read can be in flight; its flags travel with it.
    logic        rd_pend_q;
    logic        le_pend_q;
    logic        fe_pend_q;

    // Two-entry output FIFO.
    logic [23:0] pix_mem [2];
    logic [1:0]  le_mem;
    logic [1:0]  fe_mem;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    // ------------------------------------------------------------------
    // Geometry and address generation
    // ------------------------------------------------------------------
    logic [19:0] ow_m1;
    logic [19:0] oh_m1;
    logic        last_col;
    logic        last_row;
    logic [19:0] addr;

    always_comb begin
        // 90/270 swap the output width and height.
        ow_m1    = mode_q[0] ? HM1 : WM1;
        oh_m1    = mode_q[0] ? WM1 : HM1;
        last_col = (c_q == ow_m1);
        last_row = (r_q == oh_m1);
    end

    always_comb begin
        addr = '0;
        case (mode_q)
            2'd0:    addr = r_q * W20 + c_q;
            2'd1:    addr = (HM1 - c_q) * W20 + r_q;
            2'd2:    addr = (HM1 - r_q) * W20 + (WM1 - c_q);
            default: addr = c_q * W20 + (WM1 - r_q);
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and issue control
    // ------------------------------------------------------------------
    logic        push;
    logic        pop;
    logic [2:0]  slots_used;
    logic        issue;
    logic        drain_done;
    logic [1:0]  count_next;

    always_comb begin
        out_valid  = (count != 2'd0);
        pop        = out_valid && out_ready;
        push       = rd_pend_q;
        count_next = count + {1'b0, push} - {1'b0, pop};

        // Occupancy is counted after this cycle's pop, otherwise a read
        // could only be issued every other cycle. A full FIFO never issues,
        // even when it is being popped.
        slots_used = {1'b0, count} - {2'b0, pop} + {2'b0, rd_pend_q};
        issue      = (state == R_READ) && (count != 2'd2) && (slots_used < 3'd2);

        // Leave R_DRAIN as soon as the final entry is leaving, so read_finish
        // rises the cycle after the last accepted beat.
        drain_done = !rd_pend_q && ((count - {1'b0, pop}) == 2'd0);
    end

    // The read strobe must react to this cycle's pop, so it is driven
    // combinationally from registered state rather than registered itself.
    assign SRAM_EN_r   = issue;
    assign SRAM_Addr_r = issue ? addr : 20'd0;

    // ------------------------------------------------------------------
    // Frame FSM and output counters
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            state       <= R_IDLE;
            mode_q      <= 2'd0;
            r_q         <= 20'd0;
            c_q         <= 20'd0;
            read_finish <= 1'b0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (write_finish) begin
                        state  <= R_READ;
                        mode_q <= rot_mode;
                        r_q    <= 20'd0;
                        c_q    <= 20'd0;
                    end
                end
                R_READ: begin
                    if (issue) begin
                        if (last_col) begin
                            c_q <= 20'd0;
                            if (last_row) begin
                                state <= R_DRAIN;
                            end else begin
                                r_q <= r_q + 20'd1;
                            end
                        end else begin
                            c_q <= c_q + 20'd1;
                        end
                    end
                end
                R_DRAIN: begin
                    if (drain_done) begin
                        state       <= R_DONE;
                        read_finish <= 1'b1;
                    end
                end
                default: begin
                    if (!write_finish) begin
                        state       <= R_IDLE;
                        read_finish <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline and output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            rd_pend_q  <= 1'b0;
            le_pend_q  <= 1'b0;
            fe_pend_q  <= 1'b0;
            pix_mem[0] <= 24'd0;
            pix_mem[1] <= 24'd0;
            le_mem     <= 2'b00;
            fe_mem     <= 2'b00;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            rd_pend_q <= issue;
            le_pend_q <= issue && last_col;
            fe_pend_q <= issue && last_col && last_row;

            if (push) begin
                pix_mem[wr_ptr] <= SRAM_Dout;
                le_mem[wr_ptr]  <= le_pend_q;
                fe_mem[wr_ptr]  <= fe_pend_q;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: head of FIFO, zero while empty
    // ------------------------------------------------------------------
    logic [23:0] head;

    always_comb begin
        head = pix_mem[rd_ptr];
`ifdef BGR_SWAP_EN
        pixel_out = out_valid ? {head[7:0], head[15:8], head[23:16]} : 24'd0;
`else
        pixel_out = out_valid ? head : 24'd0;
`endif
        out_line_end  = out_valid && le_mem[rd_ptr];
        out_frame_end = out_valid && fe_mem[rd_ptr];
    end

endmodule

// File: tb/tb_rotate_read_controller.sv
module tb_rotate_read_controller;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wf = 1'b0;
    logic [1:0]  rm = 2'd0;
    logic        sram_en;
    logic [19:0] sram_addr;
    logic [23:0] sram_q = 24'd0;
    logic [23:0] pixel_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_line_end;
    logic        out_frame_end;
    logic        read_finish;

    logic [23:0] mem [N];

    int checks = 0;
    int errors = 0;

    // Expected output stream for the current frame.
    logic [23:0] exp_pix [N];
    bit          exp_le  [N];
    bit          exp_fe  [N];

    rotate_read_controller #(.W(W), .H(H)) dut (
        .Clk_in        (clk),
        .Reset         (rst),
        .write_finish  (wf),
        .rot_mode      (rm),
        .SRAM_EN_r     (sram_en),
        .SRAM_Addr_r   (sram_addr),
        .SRAM_Dout     (sram_q),
        .pixel_out     (pixel_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_line_end  (out_line_end),
        .out_frame_end (out_frame_end),
        .read_finish   (read_finish)
    );

    always #5 clk = ~clk;

    // SRAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (sram_en) sram_q <= mem[sram_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] vis(input logic [23:0] p);
`ifdef BGR_SWAP_EN
        return {p[7:0], p[15:8], p[23:16]};
`else
        return p;
`endif
    endfunction

    // Forward-map every input pixel (y,x) to its place in the rotated image,
    // then read the rotated image out row by row.
    task automatic build_model(input int mode);
        int ow, ro, co;
        logic [23:0] rot_img [N];
        ow = (mode % 2 == 1) ? H : W;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (mode)
                    0:       begin ro = y;         co = x;         end
                    1:       begin ro = x;         co = H - 1 - y; end
                    2:       begin ro = H - 1 - y; co = W - 1 - x; end
                    default: begin ro = W - 1 - x; co = y;         end
                endcase
                rot_img[ro * ow + co] = mem[y * W + x];
            end
        end
        for (int i = 0; i < N; i++) begin
            exp_pix[i] = vis(rot_img[i]);
            exp_le[i]  = (i % ow) == (ow - 1);
            exp_fe[i]  = (i == N - 1);
        end
    endtask

    // Runs one frame. stop_after>=0 returns just before that beat's accepting
    // edge; chg_at/drop_at change rot_mode to 0 / drop write_finish once that
    // many beats have been accepted.
    task automatic run_frame(input int mode, input bit rnd, input int stop_after,
                             input int chg_at, input int drop_at);
        int idx = 0;
        int issued = 0;
        int occ;
        int first_vld = -1;
        bit en_prev = 1'b0;
        bit held = 1'b0;
        bit last_acc = 1'b0;
        bit done_seen = 1'b0;
        logic [23:0] held_pix = 24'd0;
        build_model(mode);
        @(negedge clk);
        rm = 2'(mode);
        wf = 1'b1;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == chg_at) rm = 2'd0;
            if (idx == drop_at) wf = 1'b0;
            #1;
            occ = issued - (en_prev ? 1 : 0) - idx;
            chk("valid_vs_occupancy", {31'd0, out_valid}, {31'd0, occ > 0});
            if (sram_en) chk("read_with_fifo_full", occ, (occ < 2) ? occ : 1);
            if (held) begin
                chk("stall_pixel_held", pixel_out, held_pix);
                chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
            end
            if (last_acc) begin
                chk("read_finish_after_last", {31'd0, read_finish}, 32'd1);
                done_seen = 1'b1;
            end else begin
                chk("read_finish_early", {31'd0, read_finish}, 32'd0);
            end
            if (out_valid && first_vld < 0) begin
                first_vld = cyc;
                chk("first_valid_cycle", cyc, 2);
            end
            if (idx == stop_after) break;
            if (out_valid && out_ready && !last_acc) begin
                chk("pixel", pixel_out, exp_pix[idx]);
                chk("line_end", {31'd0, out_line_end}, {31'd0, exp_le[idx]});
                chk("frame_end", {31'd0, out_frame_end}, {31'd0, exp_fe[idx]});
                if (!rnd) chk("back_to_back", cyc, idx + 2);
                idx++;
                if (idx == N) last_acc = 1'b1;
            end
            if (sram_en) issued++;
            en_prev  = sram_en;
            held     = out_valid && !out_ready;
            held_pix = pixel_out;
        end
        if (stop_after < 0) begin
            chk("beats_in_frame", idx, N);
            chk("read_finish_seen", {31'd0, done_seen}, 32'd1);
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        wf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("idle_read_finish", {31'd0, read_finish}, 32'd0);
            chk("idle_no_read", {31'd0, sram_en}, 32'd0);
            chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_pixel"}, pixel_out, 32'd0);
        chk({tag, "_line_end"}, {31'd0, out_line_end}, 32'd0);
        chk({tag, "_frame_end"}, {31'd0, out_frame_end}, 32'd0);
        chk({tag, "_sram_en"}, {31'd0, sram_en}, 32'd0);
        chk({tag, "_sram_addr"}, sram_addr, 32'd0);
        chk({tag, "_read_finish"}, {31'd0, read_finish}, 32'd0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) mem[k] = 24'(k);

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Plain rotations with the sink always ready
        for (int m = 0; m < 4; m++) begin
            run_frame(m, 1'b0, -1, -1, -1);
            end_frame();
        end

        // Mode 1 with random backpressure
        run_frame(1, 1'b1, -1, -1, -1);
        end_frame();

        // Reset after the 6th accepted beat
        run_frame(0, 1'b0, 5, -1, -1);
        @(negedge clk);
        rst = 1'b1;
        wf  = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("mid_frame_reset");
        rst = 1'b0;

        // Rerun in mode 2, rot_mode changed to 0 mid-frame
        run_frame(2, 1'b1, -1, 4, -1);
        end_frame();

        // Random frame contents, random mode, write_finish dropped mid-frame
        for (int k = 0; k < N; k++) mem[k] = 24'($urandom);
        run_frame(int'($urandom_range(0, 3)), 1'b1, -1, -1, 5);
        end_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
